// File: rtl/linealizador.sv
// linealizador: sequential linearizer. Takes an IEEE-754 single T, computes
// GAIN*T + OFFSET on a signed Q2.30 fixed-point datapath (shift-add multiplier,
// bit-serial normalizer) and returns the result as an IEEE-754 single.
module linealizador #(
    parameter int                 P      = 32,
    parameter logic signed [31:0] GAIN   = 32'sh6000_0000,
    parameter logic signed [31:0] OFFSET = 32'sh1000_0000
) (
    input  logic         CLK,
    input  logic         RST_LN,
    input  logic         RST_FSM_LN,
    input  logic         Begin_FSM_LN,
    input  logic [P-1:0] T,
    output logic         ACK_LN,
    output logic         O_F,
    output logic         U_F,
    output logic [P-1:0] RESULT
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_MUL    = 3'd2,
        S_ADD    = 3'd3,
        S_NORM   = 3'd4,
        S_PACK   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // The multiplier works on magnitudes; the slope sign is folded back after.
    localparam logic        GAIN_NEG   = GAIN[31];
    localparam logic [31:0] GAIN_MAG   = GAIN[31] ? 32'(-GAIN) : 32'(GAIN);
    localparam logic [33:0] OFFSET_EXT = {{2{OFFSET[31]}}, OFFSET};

    // Magnitude of a normal float (|value| < 2) as Q2.30, truncated; tiny
    // values and denormals collapse to zero.
    function automatic logic [31:0] fixed_of_float(input logic [7:0] exp,
                                                   input logic [22:0] frac);
        logic [31:0] sig;
        sig = {8'd0, 1'b1, frac};
        if (exp < 8'd97) begin
            fixed_of_float = 32'd0;
        end else if (exp >= 8'd120) begin
            fixed_of_float = sig << (exp - 8'd120);
        end else begin
            fixed_of_float = sig >> (8'd120 - exp);
        end
    endfunction

    state_t      r_state;
    logic [31:0] r_t;
    logic        r_x_sign;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_prod;
    logic [4:0]  r_cnt;
    logic        r_y_sign;
    logic [31:0] r_m;

    logic [31:0] w_x_mag;
    logic [33:0] w_prod_q;
    logic [33:0] w_prod_sgn;
    logic [33:0] w_y;
    logic [33:0] w_y_abs;
    logic        w_y_ovf;
    logic        w_y_zero;
    logic        w_unused;

    assign w_x_mag    = fixed_of_float(r_t[30:23], r_t[22:0]);
    // Dropping the low 30 bits of a magnitude product truncates toward zero.
    assign w_prod_q   = r_prod[63:30];
    assign w_prod_sgn = (GAIN_NEG ^ r_x_sign) ? (34'd0 - w_prod_q) : w_prod_q;
    assign w_y        = w_prod_sgn + OFFSET_EXT;
    assign w_y_abs    = w_y[33] ? (34'd0 - w_y) : w_y;
    // Y fits the Q2.30 word only when bits 33..31 are a pure sign extension.
    assign w_y_ovf    = (w_y[33:31] != 3'b000) && (w_y[33:31] != 3'b111);
    assign w_y_zero   = (w_y == 34'd0);
    assign w_unused   = ^{r_prod[29:0], r_m[7:0], w_y_abs[33:32]};

    // Control FSM and datapath: one multiply or normalize step per cycle.
    always_ff @(posedge CLK or negedge RST_LN) begin
        if (!RST_LN) begin
            r_state  <= S_IDLE;
            r_t      <= 32'd0;
            r_x_sign <= 1'b0;
            r_mcand  <= 64'd0;
            r_mplier <= 32'd0;
            r_prod   <= 64'd0;
            r_cnt    <= 5'd0;
            r_y_sign <= 1'b0;
            r_m      <= 32'd0;
            ACK_LN   <= 1'b0;
            O_F      <= 1'b0;
            U_F      <= 1'b0;
            RESULT   <= 32'd0;
        end else if (RST_FSM_LN) begin
            r_state <= S_IDLE;
            ACK_LN  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Begin_FSM_LN) begin
                        r_t     <= T;
                        r_state <= S_DECODE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DECODE: begin
                    if (r_t[30:23] >= 8'd128) begin
                        O_F     <= 1'b1;
                        U_F     <= 1'b0;
                        RESULT  <= {r_t[31], 8'hFF, 23'd0};
                        ACK_LN  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_x_sign <= r_t[31];
                        r_mcand  <= {32'd0, w_x_mag};
                        r_mplier <= GAIN_MAG;
                        r_prod   <= 64'd0;
                        r_cnt    <= 5'd0;
                        r_state  <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (r_mplier[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end else begin
                        r_prod <= r_prod;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_ADD;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_ADD: begin
                    r_y_sign <= w_y[33];
                    if (w_y_ovf) begin
                        O_F     <= 1'b1;
                        U_F     <= 1'b0;
                        RESULT  <= {w_y[33], 8'hFF, 23'd0};
                        ACK_LN  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_y_zero) begin
                        O_F     <= 1'b0;
                        U_F     <= 1'b1;
                        RESULT  <= 32'd0;
                        ACK_LN  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_m     <= w_y_abs[31:0];
                        r_cnt   <= 5'd0;
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (r_m[31]) begin
                        r_state <= S_PACK;
                    end else begin
                        r_m   <= r_m << 1;
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_PACK: begin
                    // Leading one at 31-s gives a biased exponent of 127+(31-s)-30.
                    O_F     <= 1'b0;
                    U_F     <= 1'b0;
                    RESULT  <= {r_y_sign, 8'd128 - {3'd0, r_cnt}, r_m[30:8]};
                    ACK_LN  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    ACK_LN  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_linealizador.sv
// Bench for linealizador: two instances (default parameters and OFFSET=0)
// driven in parallel and checked against a real/integer reference model.
module tb_linealizador;

    logic        CLK;
    logic        RST_LN;
    logic        rst_fsm;
    logic        begin_fsm;
    logic [31:0] t_in;
    logic        ack_a, of_a, uf_a;
    logic [31:0] res_a;
    logic        ack_b, of_b, uf_b;
    logic [31:0] res_b;

    int n_vec = 0;
    int n_err = 0;

    localparam longint GAIN_L = 64'sd1610612736;   // 1.5 in Q2.30
    localparam longint OFF_A  = 64'sd268435456;    // 0.25 in Q2.30
    localparam longint LIM    = 64'sd2147483648;   // 2.0 in Q2.30
    localparam longint ONE_Q  = 64'sd1073741824;   // 1.0 in Q2.30

    linealizador u_dut (
        .CLK(CLK), .RST_LN(RST_LN), .RST_FSM_LN(rst_fsm), .Begin_FSM_LN(begin_fsm),
        .T(t_in), .ACK_LN(ack_a), .O_F(of_a), .U_F(uf_a), .RESULT(res_a)
    );

    linealizador #(.OFFSET(32'sh0000_0000)) u_dut_z (
        .CLK(CLK), .RST_LN(RST_LN), .RST_FSM_LN(rst_fsm), .Begin_FSM_LN(begin_fsm),
        .T(t_in), .ACK_LN(ack_b), .O_F(of_b), .U_F(uf_b), .RESULT(res_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: real-valued T, exact integer product, truncation toward zero,
    // then float packing from floor(log2). Returns {O_F, U_F, RESULT}.
    function automatic logic [33:0] ref_model(input logic [31:0] t, input longint off);
        int     e;
        int     k;
        real    v;
        longint x, p, y, mag, m;
        logic   s;
        e = int'(t[30:23]);
        if (e >= 128) return {1'b1, 1'b0, t[31], 8'hFF, 23'h0};
        if (e == 0) begin
            v = 0.0;
        end else begin
            v = 1.0 + real'(t[22:0]) / 8388608.0;
            for (int i = e; i < 127; i++) v = v / 2.0;
        end
        x = longint'($floor(v * 1073741824.0));
        if (t[31]) x = -x;
        p = (GAIN_L * x) / ONE_Q;
        y = p + off;
        s = (y < 0);
        if (y < -LIM || y >= LIM) return {2'b10, s, 8'hFF, 23'h0};
        if (y == 0) return {2'b01, 32'h0};
        mag = s ? -y : y;
        k = 0;
        while ((mag >> (k + 1)) != 0) k++;
        if (k >= 23) m = (mag >> (k - 23)) - 64'sd8388608;
        else         m = (mag << (23 - k)) - 64'sd8388608;
        return {2'b00, s, 8'(127 + k - 30), m[22:0]};
    endfunction

    // Pulse Begin with operand t, then wait (bounded) for both ACKs.
    task automatic run_op(input logic [31:0] t);
        int c;
        @(negedge CLK);
        t_in      = t;
        begin_fsm = 1'b1;
        @(negedge CLK);
        begin_fsm = 1'b0;
        t_in      = $urandom;
        c = 0;
        while (!(ack_a && ack_b) && c < 70) begin
            @(negedge CLK);
            c++;
        end
        n_vec++;
        if (!(ack_a && ack_b)) begin
            n_err++;
            $display("FAIL latency: ack_a=%b ack_b=%b after %0d cycles, required 1 within 70", ack_a, ack_b, c);
        end
    endtask

    // One-cycle FSM clear.
    task automatic clear_fsm();
        @(negedge CLK);
        rst_fsm = 1'b1;
        @(negedge CLK);
        rst_fsm = 1'b0;
    endtask

    task automatic test_reset();
        RST_LN    = 1'b0;
        rst_fsm   = 1'b0;
        begin_fsm = 1'b0;
        t_in      = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        n_vec++;
        if ({ack_a, of_a, uf_a, res_a, ack_b, of_b, uf_b, res_b} !== 70'd0) begin
            n_err++;
            $display("FAIL reset_init: got a=%b%b%b %h b=%b%b%b %h, required all zero",
                     ack_a, of_a, uf_a, res_a, ack_b, of_b, uf_b, res_b);
        end
        @(negedge CLK);
        RST_LN = 1'b1;
        run_op(32'h3F00_0000);
        clear_fsm();
        // Start a new operation, then pull reset while the multiplier runs.
        @(negedge CLK);
        t_in      = 32'h3EA0_0000;
        begin_fsm = 1'b1;
        @(negedge CLK);
        begin_fsm = 1'b0;
        repeat (10) @(negedge CLK);
        RST_LN = 1'b0;
        #1;
        n_vec++;
        if ({ack_a, of_a, uf_a, res_a} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_mid_op: got ack=%b of=%b uf=%b res=%h, required 0 0 0 00000000",
                     ack_a, of_a, uf_a, res_a);
        end
        @(negedge CLK);
        RST_LN = 1'b1;
        repeat (80) @(negedge CLK);
        n_vec++;
        if ({ack_a, res_a, ack_b} !== 34'd0) begin
            n_err++;
            $display("FAIL reset_idle: got ack_a=%b res_a=%h ack_b=%b, required idle zeros", ack_a, res_a, ack_b);
        end
    endtask

    task automatic test_directed();
        logic [31:0] tv[6] = '{32'h3F00_0000, 32'h3EA0_0000, 32'h0000_0000,
                               32'hBF00_0000, 32'h3FA0_0000, 32'h7FC0_0000};
        logic [33:0] ea[6] = '{{2'b00, 32'h3F80_0000}, {2'b00, 32'h3F38_0000},
                               {2'b00, 32'h3E80_0000}, {2'b00, 32'hBF00_0000},
                               {2'b10, 32'h7F80_0000}, {2'b10, 32'h7F80_0000}};
        logic [33:0] eb;
        for (int i = 0; i < 6; i++) begin
            run_op(tv[i]);
            n_vec++;
            if ({of_a, uf_a, res_a} !== ea[i]) begin
                n_err++;
                $display("FAIL directed_a T=%h: got of=%b uf=%b res=%h, required %h", tv[i], of_a, uf_a, res_a, ea[i]);
            end
            eb = (tv[i] == 32'h0) ? {2'b01, 32'h0} : ref_model(tv[i], 64'sd0);
            n_vec++;
            if ({of_b, uf_b, res_b} !== eb) begin
                n_err++;
                $display("FAIL directed_b T=%h: got of=%b uf=%b res=%h, required %h", tv[i], of_b, uf_b, res_b, eb);
            end
            clear_fsm();
            n_vec++;
            if ({ack_a, of_a, uf_a, res_a} !== {1'b0, ea[i]}) begin
                n_err++;
                $display("FAIL fsm_clear T=%h: got ack=%b of=%b uf=%b res=%h, required ack 0 and result kept",
                         tv[i], ack_a, of_a, uf_a, res_a);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_op(32'h3F00_0000);
        repeat (5) @(negedge CLK);
        t_in      = 32'h3EA0_0000;
        begin_fsm = 1'b1;
        @(negedge CLK);
        begin_fsm = 1'b0;
        repeat (80) @(negedge CLK);
        n_vec++;
        if ({ack_a, res_a} !== {1'b1, 32'h3F80_0000}) begin
            n_err++;
            $display("FAIL done_hold: got ack=%b res=%h, required 1 3f800000", ack_a, res_a);
        end
        clear_fsm();
        run_op(32'h3EA0_0000);
        n_vec++;
        if ({of_a, uf_a, res_a} !== {2'b00, 32'h3F38_0000}) begin
            n_err++;
            $display("FAIL restart: got of=%b uf=%b res=%h, required 0 0 3f380000", of_a, uf_a, res_a);
        end
        clear_fsm();
    endtask

    task automatic test_clear_priority();
        logic seen;
        seen = 1'b0;
        @(negedge CLK);
        t_in      = 32'h3F00_0000;
        rst_fsm   = 1'b1;
        begin_fsm = 1'b1;
        @(negedge CLK);
        rst_fsm   = 1'b0;
        begin_fsm = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK);
            if (ack_a || ack_b) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL clear_priority: got ack seen=%b, required 0", seen);
        end
    endtask

    task automatic test_random();
        logic [31:0] t;
        logic [7:0]  e;
        logic [33:0] ea, eb;
        for (int i = 0; i < 40; i++) begin
            e = 8'($urandom_range(130, 88));
            if (i % 8 == 3) e = 8'h00;
            if (i % 8 == 7) e = 8'hFF;
            t = {1'($urandom), e, 23'($urandom)};
            run_op(t);
            ea = ref_model(t, OFF_A);
            eb = ref_model(t, 64'sd0);
            n_vec++;
            if ({of_a, uf_a, res_a} !== ea) begin
                n_err++;
                $display("FAIL random_a T=%h: got of=%b uf=%b res=%h, required %h", t, of_a, uf_a, res_a, ea);
            end
            n_vec++;
            if ({of_b, uf_b, res_b} !== eb) begin
                n_err++;
                $display("FAIL random_b T=%h: got of=%b uf=%b res=%h, required %h", t, of_b, uf_b, res_b, eb);
            end
            clear_fsm();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_clear_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
